mixer_tdm_ctrl: RTL and testbench
=================================

MIXER_TDM_CTRL -- requirements
Module: mixer_tdm_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, 12, signed sample/LO/output width.
REQ-002 SHALL have port: clock  input  1  sole clock, all logic on rising edge.
REQ-003 SHALL have port: clock_sreset  input  1  synchronous reset, active-high.
REQ-004 SHALL have port: in_valid  input  1  sample and LO pair presented.
REQ-005 SHALL have port: in_ready  output  1  block accepts the sample this cycle.
REQ-006 SHALL have port: data_in  input  WIDTH  signed RF sample.
REQ-007 SHALL have port: sine_in  input  WIDTH  signed LO sine.
REQ-008 SHALL have port: cosine_in  input  WIDTH  signed LO cosine.
REQ-009 SHALL have port: sine_out  output  WIDTH  signed data*sine result.
REQ-010 SHALL have port: cosine_out  output  WIDTH  signed data*cosine result.
REQ-011 SHALL have port: out_valid  output  1  one-cycle pulse; both outputs updated together.

Function
REQ-012 SHALL time-share one signed WIDTHxWIDTH multiplier (2-cycle pipeline, 2*WIDTH-bit product) between the sine and cosine products.
REQ-013 SHALL implement FSM states IDLE and COS; reset state IDLE.
REQ-014 SHALL assert in_ready only in IDLE; accept = in_valid && in_ready.
REQ-015 On accept (cycle T): SHALL issue data_in*sine_in to the multiplier, latch data_in and cosine_in, and enter COS.
REQ-016 In COS (cycle T+1): SHALL issue latched data*cosine, ignore in_valid, and return to IDLE.
REQ-017 IDLE with no accept SHALL issue nothing and stay in IDLE.
REQ-018 Maximum throughput SHALL be one sample per 2 cycles; in_valid held high gives in_ready 1,0,1,0,...
REQ-019 SHALL carry a 2-bit valid/tag shift register alongside the multiplier pipeline, marking sine and cosine products.
REQ-020 SHALL hold the sine product when it emerges (T+2), register both results when the cosine product emerges (T+3), and pulse out_valid in cycle T+4.
REQ-021 Without saturation, each output SHALL be product bits [WIDTH-1:0] (wrap).
REQ-022 sine_out and cosine_out SHALL hold their last value between out_valid pulses.
REQ-023 Back-to-back samples SHALL produce out_valid pulses exactly 2 cycles apart, in accept order, with no mixing of pairs.

Reset
REQ-024 Reset SHALL set: state IDLE, in_ready 1 in the first cycle after reset, out_valid 0, sine_out 0, cosine_out 0, tag pipeline cleared, hold register 0.
REQ-025 Reset mid-operation SHALL discard all in-flight products; no out_valid for samples accepted before reset.
REQ-026 in_valid during reset SHALL not be accepted.

Configuration
REQ-027 Macro MIXER_TDM_SAT_EN defined: each output SHALL saturate the full product to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-028 Macro MIXER_TDM_SAT_EN undefined: outputs SHALL be product bits [WIDTH-1:0] (REQ-021); no saturation logic synthesised.

Structure
REQ-029 Package mixer_tdm_pkg SHALL hold the FSM state enum, the multiplier latency constant (2) and the tag encoding.
REQ-030 The pipelined signed multiplier SHALL be a sub-module mult_pipe (parameters WIDTH, latency); the controller holds the FSM, operand mux, tags and output registers.

Verification (WIDTH=12)
REQ-031 Single sample: data 100, sine 5, cosine -3 accepted at T -> out_valid at T+4 only, sine_out 500, cosine_out -300.
REQ-032 Streaming: in_valid high 6 cycles with pairs (1,2,3), (4,5,6), (7,8,9) -> in_ready 1,0,1,0,1,0; outputs (2,3), (20,24), (56,63) at T+4, T+6, T+8.
REQ-033 Overflow: data 2047, sine 2047, cosine -2048 -> no macro: sine_out 1, cosine_out -2048; MIXER_TDM_SAT_EN: sine_out 2047, cosine_out -2048.
REQ-034 Reset mid-op: accept at T, clock_sreset high at T+1 -> no out_valid ever; outputs 0; in_ready 1 in the first cycle after reset.
REQ-035 Gapped input: one in_valid pulse every 5 cycles, random values -> each out_valid 4 cycles after its accept; results match the reference product model.

Source files
------------

// File: rtl/mixer_tdm_pkg.sv
// Shared definitions for the time-shared I/Q mixer: controller states,
// multiplier latency and the tags that mark which product is in flight.
package mixer_tdm_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        COS  = 1'b1
    } state_t;

    localparam int MULT_LATENCY = 2;

    typedef enum logic [1:0] {
        TAG_NONE = 2'b00,
        TAG_SIN  = 2'b01,
        TAG_COS  = 2'b10
    } tag_t;

endpackage

// File: rtl/mixer_tdm_mult_pipe.sv
// Pipelined signed WIDTHxWIDTH multiplier. The operands are registered
// first, then the product travels through LATENCY-1 register stages.
// No reset: the controller's tag pipeline decides which outputs are valid.
module mult_pipe #(
    parameter int WIDTH   = 12,
    parameter int LATENCY = 2
) (
    input  logic                      clock,
    input  logic signed [WIDTH-1:0]   a,
    input  logic signed [WIDTH-1:0]   b,
    output logic signed [2*WIDTH-1:0] p
);

    logic signed [WIDTH-1:0]   a_reg;
    logic signed [WIDTH-1:0]   b_reg;
    logic signed [2*WIDTH-1:0] prod_pipe [LATENCY-1];

    // Operand capture, multiply, then delay the product to the full latency
    always_ff @(posedge clock) begin
        a_reg        <= a;
        b_reg        <= b;
        prod_pipe[0] <= a_reg * b_reg;
        for (int i = 1; i < LATENCY - 1; i++) begin
            prod_pipe[i] <= prod_pipe[i-1];
        end
    end

    assign p = prod_pipe[LATENCY-2];

endmodule

// File: rtl/mixer_tdm_ctrl.sv
// Time-shared I/Q mixer controller: one multiplier computes data*sine and
// then data*cosine for each accepted sample, and both results are
// presented together with a one-cycle out_valid pulse.
// Optional feature: define MIXER_TDM_SAT_EN to saturate each output to the
// WIDTH-bit signed range instead of keeping the low product bits.
module mixer_tdm_ctrl
    import mixer_tdm_pkg::*;
#(
    parameter int WIDTH = 12
) (
    input  logic                    clock,
    input  logic                    clock_sreset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] data_in,
    input  logic signed [WIDTH-1:0] sine_in,
    input  logic signed [WIDTH-1:0] cosine_in,
    output logic signed [WIDTH-1:0] sine_out,
    output logic signed [WIDTH-1:0] cosine_out,
    output logic                    out_valid
);

    state_t                    state;
    state_t                    next_state;
    logic                      accept;
    logic signed [WIDTH-1:0]   data_lat;
    logic signed [WIDTH-1:0]   cos_lat;
    logic signed [WIDTH-1:0]   mul_a;
    logic signed [WIDTH-1:0]   mul_b;
    tag_t                      issue_tag;
    tag_t                      tag_pipe [MULT_LATENCY];
    tag_t                      tag_out;
    logic signed [2*WIDTH-1:0] product;
    logic signed [2*WIDTH-1:0] hold_reg;
    logic signed [WIDTH-1:0]   sine_fit;
    logic signed [WIDTH-1:0]   cos_fit;

    // State register
    always_ff @(posedge clock) begin
        if (clock_sreset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state, handshake and operand mux: sine on accept, cosine one cycle later
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        accept     = 1'b0;
        mul_a      = data_lat;
        mul_b      = cos_lat;
        issue_tag  = TAG_NONE;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (in_valid) begin
                    mul_a      = data_in;
                    mul_b      = sine_in;
                    issue_tag  = TAG_SIN;
                    next_state = COS;
                end
            end
            COS: begin
                issue_tag  = TAG_COS;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Keep the sample and cosine so the second product can be issued next cycle
    always_ff @(posedge clock) begin
        if (clock_sreset) begin
            data_lat <= '0;
            cos_lat  <= '0;
        end else if (accept) begin
            data_lat <= data_in;
            cos_lat  <= cosine_in;
        end
    end

    mult_pipe #(
        .WIDTH   (WIDTH),
        .LATENCY (MULT_LATENCY)
    ) u_mult (
        .clock (clock),
        .a     (mul_a),
        .b     (mul_b),
        .p     (product)
    );

    // Tag shift register that travels in step with the multiplier pipeline
    always_ff @(posedge clock) begin
        if (clock_sreset) begin
            for (int i = 0; i < MULT_LATENCY; i++) begin
                tag_pipe[i] <= TAG_NONE;
            end
        end else begin
            tag_pipe[0] <= issue_tag;
            for (int i = 1; i < MULT_LATENCY; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    assign tag_out = tag_pipe[MULT_LATENCY-1];

`ifdef MIXER_TDM_SAT_EN
    // Clamp a full product to the signed WIDTH-bit range
    function automatic logic signed [WIDTH-1:0] fit(input logic signed [2*WIDTH-1:0] p);
        logic [WIDTH:0] top;
        top = p[2*WIDTH-1:WIDTH-1];
        if ((&top) || !(|top)) begin
            fit = p[WIDTH-1:0];
        end else if (p[2*WIDTH-1]) begin
            fit = {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            fit = {1'b0, {(WIDTH-1){1'b1}}};
        end
    endfunction

    assign sine_fit = fit(hold_reg);
    assign cos_fit  = fit(product);
`else
    logic unused_upper;

    assign sine_fit     = hold_reg[WIDTH-1:0];
    assign cos_fit      = product[WIDTH-1:0];
    assign unused_upper = ^{hold_reg[2*WIDTH-1:WIDTH], product[2*WIDTH-1:WIDTH]};
`endif

    // Park the sine product, then publish both results when the cosine arrives
    always_ff @(posedge clock) begin
        if (clock_sreset) begin
            hold_reg   <= '0;
            sine_out   <= '0;
            cosine_out <= '0;
            out_valid  <= 1'b0;
        end else begin
            out_valid <= (tag_out == TAG_COS);
            if (tag_out == TAG_SIN) begin
                hold_reg <= product;
            end
            if (tag_out == TAG_COS) begin
                sine_out   <= sine_fit;
                cosine_out <= cos_fit;
            end
        end
    end

endmodule

// File: tb/tb_mixer_tdm_ctrl.sv
// Self-checking bench for mixer_tdm_ctrl: directed table vectors, streaming,
// reset mid-operation and gapped random traffic against a product model.
module tb_mixer_tdm_ctrl;

    localparam int WIDTH = 12;

    logic                    clock = 1'b0;
    logic                    clock_sreset;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH-1:0] data_in;
    logic signed [WIDTH-1:0] sine_in;
    logic signed [WIDTH-1:0] cosine_in;
    logic signed [WIDTH-1:0] sine_out;
    logic signed [WIDTH-1:0] cosine_out;
    logic                    out_valid;

    mixer_tdm_ctrl #(.WIDTH(WIDTH)) dut (
        .clock        (clock),
        .clock_sreset (clock_sreset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .data_in      (data_in),
        .sine_in      (sine_in),
        .cosine_in    (cosine_in),
        .sine_out     (sine_out),
        .cosine_out   (cosine_out),
        .out_valid    (out_valid)
    );

    // Free-running clock
    always #5 clock = ~clock;

    typedef struct {
        int due;
        int s;
        int c;
    } pend_t;

    typedef struct {
        int d;
        int s;
        int c;
        int exp_s;
        int exp_c;
    } vec_t;

    int    vectors     = 0;
    int    miscompares = 0;
    int    cycle_num   = 0;
    pend_t pend_q[$];
    bit    model_ready = 1'b1;
    int    exp_sin     = 0;
    int    exp_cos     = 0;
    vec_t  tbl [5];

    // Reference result of a*b reduced to WIDTH bits (wrap or clamp)
    function automatic int ref_out(input int a, input int b);
        longint p;
        longint lo;
        longint hi;
        longint m;
        p  = longint'(a) * longint'(b);
        lo = -(longint'(1) << (WIDTH - 1));
        hi = (longint'(1) << (WIDTH - 1)) - 1;
`ifdef MIXER_TDM_SAT_EN
        if (p > hi) return int'(hi);
        if (p < lo) return int'(lo);
        return int'(p);
`else
        m = p % (longint'(1) << WIDTH);
        if (m < 0) m = m + (longint'(1) << WIDTH);
        if (m > hi) m = m - (longint'(1) << WIDTH);
        return int'(m);
`endif
    endfunction

    // Single comparison with failure report
    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cycle_num, act, exp);
        end
    endtask

    // Compare registered outputs against the model for the current cycle
    task automatic checkOutput();
        bit exp_valid;
        exp_valid = 1'b0;
        if (pend_q.size() > 0 && pend_q[0].due == cycle_num) begin
            exp_valid = 1'b1;
            exp_sin   = pend_q[0].s;
            exp_cos   = pend_q[0].c;
            void'(pend_q.pop_front());
        end
        check("out_valid", int'(out_valid), int'(exp_valid));
        check("sine_out", int'(sine_out), exp_sin);
        check("cosine_out", int'(cosine_out), exp_cos);
    endtask

    // Drive one cycle of inputs, advance the model and check the outputs
    task automatic applyStimulus(input bit rst, input bit v, input int d, input int s, input int c);
        bit acc;
        clock_sreset = rst;
        in_valid     = v;
        data_in      = d[WIDTH-1:0];
        sine_in      = s[WIDTH-1:0];
        cosine_in    = c[WIDTH-1:0];
        if (!rst) check("in_ready", int'(in_ready), int'(model_ready));
        acc = v && model_ready && !rst;
        if (acc) pend_q.push_back('{cycle_num + 4, ref_out(d, s), ref_out(d, c)});
        @(posedge clock);
        #1;
        cycle_num++;
        if (rst) begin
            pend_q.delete();
            model_ready = 1'b1;
            exp_sin     = 0;
            exp_cos     = 0;
        end else begin
            model_ready = !acc;
        end
        checkOutput();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 0, 0, 0);
    endtask

    initial begin
        clock_sreset = 1'b1;
        in_valid     = 1'b0;
        data_in      = '0;
        sine_in      = '0;
        cosine_in    = '0;

`ifdef MIXER_TDM_SAT_EN
        tbl[0] = '{100, 5, -3, 500, -300};
        tbl[1] = '{2047, 2047, -2048, 2047, -2048};
        tbl[2] = '{-2048, -2048, 1, 2047, -2048};
        tbl[3] = '{-7, 3, -9, -21, 63};
        tbl[4] = '{64, 64, -64, 2047, -2048};
`else
        tbl[0] = '{100, 5, -3, 500, -300};
        tbl[1] = '{2047, 2047, -2048, 1, -2048};
        tbl[2] = '{-2048, -2048, 1, 0, -2048};
        tbl[3] = '{-7, 3, -9, -21, 63};
        tbl[4] = '{64, 64, -64, 0, 0};
`endif

        // Reset with in_valid high: nothing must be accepted
        applyStimulus(1'b1, 1'b1, 11, 22, 33);
        applyStimulus(1'b1, 1'b0, 0, 0, 0);
        idle(2);

        // Directed single samples with fixed expected results
        foreach (tbl[k]) begin
            applyStimulus(1'b0, 1'b1, tbl[k].d, tbl[k].s, tbl[k].c);
            idle(5);
            check("tbl_sine", int'(sine_out), tbl[k].exp_s);
            check("tbl_cosine", int'(cosine_out), tbl[k].exp_c);
        end

        // Streaming: in_valid held high, new pair on every accepted cycle
        for (int i = 0; i < 6; i++) begin
            int k;
            k = i / 2;
            check("stream_ready", int'(in_ready), (i % 2 == 0) ? 1 : 0);
            applyStimulus(1'b0, 1'b1, 3 * k + 1, 3 * k + 2, 3 * k + 3);
        end
        idle(6);
        check("stream_last_sine", int'(sine_out), 56);
        check("stream_last_cosine", int'(cosine_out), 63);

        // Reset one cycle after an accept discards the sample
        applyStimulus(1'b0, 1'b1, 9, 9, 9);
        applyStimulus(1'b1, 1'b1, 5, 5, 5);
        check("post_reset_ready", int'(in_ready), 1);
        idle(8);

        // Gapped random traffic: one pulse every 5 cycles
        for (int n = 0; n < 20; n++) begin
            int d;
            int s;
            int c;
            d = int'($urandom_range(0, 4095)) - 2048;
            s = int'($urandom_range(0, 4095)) - 2048;
            c = int'($urandom_range(0, 4095)) - 2048;
            applyStimulus(1'b0, 1'b1, d, s, c);
            idle(4);
        end

        // Random back-to-back bursts
        for (int n = 0; n < 40; n++) begin
            applyStimulus(1'b0, $urandom_range(0, 1) == 1,
                          int'($urandom_range(0, 4095)) - 2048,
                          int'($urandom_range(0, 4095)) - 2048,
                          int'($urandom_range(0, 4095)) - 2048);
        end
        idle(6);
        check("queue_drained", pend_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
